ex_muldiv: RTL and testbench
============================

Name: ex_muldiv

Overview:
- Iterative multiply/divide unit in the EX stage. Consumes the register operands and decoded op latched by the ID/EX pipeline register.
- Owns the HI/LO architectural registers and executes MULT/MULTU/DIV/DIVU over multiple cycles.
- Raises busy so hazard control stalls IF/ID/EX while an operation is in flight, and serves MFHI/MFLO/MTHI/MTLO.

Parameters:
WIDTH, 32, operand width; HI/LO are WIDTH bits each; the iteration count equals WIDTH.

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-low
start  in  1  launch the op on op_in using src_a/src_b; sampled only in IDLE
op_in  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
src_a  in  WIDTH  multiplicand / dividend (DataBus_A after forwarding)
src_b  in  WIDTH  multiplier / divisor (DataBus_B after forwarding)
abort  in  1  pipeline flush; cancels the in-flight op
hi_wr  in  1  MTHI write
lo_wr  in  1  MTLO write
wr_data  in  WIDTH  data for MTHI/MTLO
busy  out  1  op in flight; stall request to hazard unit
done  out  1  one-cycle pulse when HI/LO take a new result
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- Reset (reset==0 at a clk edge): state=IDLE, busy=0, done=0, hi=0, lo=0, all internal accumulators 0. Reset mid-operation discards the op.
- States:
  - IDLE: start=1 and abort=0 → latch magnitudes (|a|,|b| for signed ops, raw for unsigned), latch sign flags, cnt=0 → RUN.
  - RUN: one step per cycle. Multiply is shift-add on a 2*WIDTH accumulator. Divide is a restoring step: shift remainder, subtract divisor if no borrow, set quotient bit. cnt increments; at cnt==WIDTH-1 → FIX.
  - FIX: apply the sign correction, write HI/LO, → IDLE.
- Sign correction:
  - Signed multiply: negate the 2*WIDTH product if sign(a)^sign(b).
  - Signed divide: negate the quotient if sign(a)^sign(b); the remainder takes the sign of a.
  - Results: HI=product[2W-1:W], LO=product[W-1:0]. For divide, LO=quotient, HI=remainder.
- Latency:
  - start sampled at edge 0; busy=1 from after edge 0 through the FIX cycle.
  - HI/LO updated at edge WIDTH+1; done=1 and busy=0 during the following cycle.
  - Total 34 cycles for WIDTH=32, independent of op.
- Divide by zero: no special path. The restoring algorithm yields quotient all-ones and remainder |a|, then sign fix applies. Signed: LO=(a<0 ? 1 : 0xFFFFFFFF), HI=a.
- Signed overflow (0x80000000 / 0xFFFFFFFF): LO=0x80000000, HI=0 (falls out naturally; must be verified).
- start while busy: ignored.
- abort in RUN or FIX: → IDLE next edge; HI/LO unchanged; done stays 0.
- abort and start together in IDLE: abort wins, nothing launched.
- hi_wr/lo_wr:
  - Honoured only in IDLE, effective the next edge; both may be asserted together.
  - Ignored while busy (the pipeline is stalled anyway).
  - Simultaneous with start: the MT write takes effect, then the op result later overwrites it.
- hi/lo are combinational from the registers. The reader (MFHI/MFLO) is stalled while busy=1.

Optional Feature:
Macro MULDIV_EARLY_OUT_EN.
- Defined, unsigned view: in RUN for multiply, when the remaining unshifted multiplier bits are all zero, jump directly to FIX. The accumulator is aligned by the remaining shift count in FIX. Latency becomes variable, minimum 3 cycles (multiplier magnitude 0 or 1). Divide is unaffected.
- Undefined: fixed WIDTH+2 latency for all ops. No extra shifter logic.

Decomposition:
- Package muldiv_pkg: op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU), state encoding (ST_IDLE, ST_RUN, ST_FIX), counter width constant clog2(WIDTH).
- One natural sub-module, muldiv_divstep: combinational single restoring-division step (remainder, divisor, dividend bit → next remainder, quotient bit).
- The FSM, accumulators and HI/LO live in ex_muldiv.

Test Plan:
- MULTU 0xFFFFFFFF × 0xFFFFFFFF, start at cycle 0 → done at cycle 34, HI=0xFFFFFFFE, LO=0x00000001, busy high cycles 1–33.
- MULT −7 × 3 → HI=0xFFFFFFFF, LO=0xFFFFFFEB; DIV −7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 100 / 0 → LO=0xFFFFFFFF, HI=100. DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- MTHI 0x1234 then DIVU 9/4 started; abort at cycle 10 → busy falls after the abort edge, no done pulse, HI=0x1234, LO unchanged. A second start during RUN is ignored.
- reset=0 asserted at cycle 20 of a MULT → next cycle busy=0, hi=lo=0, state IDLE. A new MULTU 6×7 then yields LO=42, HI=0.
- With MULDIV_EARLY_OUT_EN: MULTU 5×1 → done within 3 cycles, LO=5. Without it, the same op completes in 34 cycles.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings for the EX-stage multiply/divide unit.
package muldiv_pkg;

   localparam int MD_WIDTH = 32;
   localparam int CNT_W    = $clog2(MD_WIDTH);

   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } md_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_FIX  = 2'b10
   } md_state_e;

   // Signed ops have op[0] clear; divides have op[1] set.
   function automatic logic op_is_signed(input logic [1:0] op);
      return ~op[0];
   endfunction

   function automatic logic op_is_div(input logic [1:0] op);
      return op[1];
   endfunction

endpackage

// File: rtl/muldiv_divstep.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when that does not borrow.
module muldiv_divstep #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem_in,
   input  logic [WIDTH-1:0] divisor,
   input  logic             dbit,
   output logic [WIDTH-1:0] rem_out,
   output logic             qbit
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] diff;

   // The partial remainder is always below the divisor, so the shifted value
   // is below twice the divisor and diff[WIDTH] is a true borrow flag.
   assign shifted = {rem_in, dbit};
   assign diff    = shifted - {1'b0, divisor};
   assign qbit    = ~diff[WIDTH];
   assign rem_out = qbit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage iterative multiply/divide unit owning HI/LO.
// Build option MULDIV_EARLY_OUT_EN: multiplies leave RUN as soon as the
// remaining multiplier bits are zero; the accumulator is realigned in FIX.
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_IDLE | HI/LO readable and writable (MTHI/MTLO), waiting for start
// ST_RUN  | one shift-add or restoring-divide step per cycle
// ST_FIX  | sign correction, HI/LO write, done pulse next cycle
module ex_muldiv
   import muldiv_pkg::*;
#(
   parameter int WIDTH = MD_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op_in,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic             abort,
   input  logic             hi_wr,
   input  logic             lo_wr,
   input  logic [WIDTH-1:0] wr_data,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH);

   md_state_e          state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   opb_q, opb_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic [1:0]         op_q, op_d;
   logic               neg_a_q, neg_a_d;
   logic               neg_b_q, neg_b_d;
   logic               done_q, done_d;

   logic               a_neg, b_neg;
   logic [WIDTH-1:0]   abs_a, abs_b;
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next, div_next, step_acc, fix_acc;
   logic [WIDTH-1:0]   div_rem;
   logic               div_qbit;
   logic [WIDTH-1:0]   quo, rem;
   logic               run_last;

   assign a_neg = op_is_signed(op_in) & src_a[WIDTH-1];
   assign b_neg = op_is_signed(op_in) & src_b[WIDTH-1];
   assign abs_a = a_neg ? -src_a : src_a;
   assign abs_b = b_neg ? -src_b : src_b;

   // Multiply: acc = {partial product, unconsumed multiplier}, opb = multiplicand.
   assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, {WIDTH{acc_q[0]}} & opb_q};
   assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

   // Divide: acc = {partial remainder, dividend bits then quotient bits}, opb = divisor.
   muldiv_divstep #(.WIDTH(WIDTH)) u_divstep (
      .rem_in  (acc_q[2*WIDTH-1:WIDTH]),
      .divisor (opb_q),
      .dbit    (acc_q[WIDTH-1]),
      .rem_out (div_rem),
      .qbit    (div_qbit)
   );
   assign div_next = {div_rem, acc_q[WIDTH-2:0], div_qbit};
   assign step_acc = op_is_div(op_q) ? div_next : mul_next;

`ifdef MULDIV_EARLY_OUT_EN
   logic [CW-1:0]    shift_q, shift_d;
   logic [WIDTH-1:0] live_mask;

   // Bits of the stepped multiplier still waiting to be consumed.
   assign live_mask = ({WIDTH{1'b1}} >> cnt_q) >> 1;
   assign run_last  = op_is_div(op_q) ? (cnt_q == CW'(WIDTH-1))
                                      : ((mul_next[WIDTH-1:0] & live_mask) == '0);
   assign fix_acc   = acc_q >> shift_q;

   // Remaining shift count captured on early exit.
   always_ff @(posedge clk) begin
      if (!reset) shift_q <= '0;
      else        shift_q <= shift_d;
   end

   // Launch clears the realignment; leaving RUN records steps skipped.
   always_comb begin
      shift_d = shift_q;
      if (state_q == ST_IDLE && start && !abort)
         shift_d = '0;
      else if (state_q == ST_RUN && !abort && run_last && !op_is_div(op_q))
         shift_d = CW'(WIDTH-1) - cnt_q;
   end
`else
   assign run_last = (cnt_q == CW'(WIDTH-1));
   assign fix_acc  = acc_q;
`endif

   assign quo = fix_acc[WIDTH-1:0];
   assign rem = fix_acc[2*WIDTH-1:WIDTH];

   // State, datapath and architectural register flops.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         opb_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         op_q    <= '0;
         neg_a_q <= 1'b0;
         neg_b_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         opb_q   <= opb_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         op_q    <= op_d;
         neg_a_q <= neg_a_d;
         neg_b_q <= neg_b_d;
         done_q  <= done_d;
      end
   end

   // Next-state and datapath update for the IDLE/RUN/FIX sequence.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      opb_d   = opb_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      op_d    = op_q;
      neg_a_d = neg_a_q;
      neg_b_d = neg_b_q;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (hi_wr) hi_d = wr_data;
            if (lo_wr) lo_d = wr_data;
            if (start && !abort) begin
               state_d = ST_RUN;
               cnt_d   = '0;
               op_d    = op_in;
               neg_a_d = a_neg;
               neg_b_d = b_neg;
               acc_d   = {{WIDTH{1'b0}}, op_is_div(op_in) ? abs_a : abs_b};
               opb_d   = op_is_div(op_in) ? abs_b : abs_a;
            end
         end
         ST_RUN: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else begin
               acc_d = step_acc;
               cnt_d = cnt_q + 1'b1;
               if (run_last) state_d = ST_FIX;
            end
         end
         ST_FIX: begin
            state_d = ST_IDLE;
            if (!abort) begin
               done_d = 1'b1;
               if (op_is_div(op_q)) begin
                  lo_d = (neg_a_q ^ neg_b_q) ? -quo : quo;
                  hi_d = neg_a_q ? -rem : rem;
               end else begin
                  {hi_d, lo_d} = (neg_a_q ^ neg_b_q) ? -fix_acc : fix_acc;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign busy = (state_q != ST_IDLE);
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: scoreboard of {HI,LO} results popped on done.
module tb_ex_muldiv;

   logic        clk, reset, start, abort, hi_wr, lo_wr;
   logic [1:0]  op_in;
   logic [31:0] src_a, src_b, wr_data, hi, lo;
   logic        busy, done;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [63:0] sb_q[$];
   logic [31:0] exp_hi = 0, exp_lo = 0;

   ex_muldiv #(.WIDTH(32)) dut (
      .clk(clk), .reset(reset), .start(start), .op_in(op_in),
      .src_a(src_a), .src_b(src_b), .abort(abort), .hi_wr(hi_wr),
      .lo_wr(lo_wr), .wr_data(wr_data), .busy(busy), .done(done),
      .hi(hi), .lo(lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r;
      logic [63:0] res;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      res = '0;
      case (op)
         2'b00: res = 64'(sa * sb);
         2'b01: res = {32'b0, a} * {32'b0, b};
         2'b10: begin
            if (b == 0) res = {a, (a[31] ? 32'h1 : 32'hFFFF_FFFF)};
            else begin
               q = sa / sb;
               r = sa % sb;
               res = {r[31:0], q[31:0]};
            end
         end
         default: begin
            if (b == 0) res = {a, 32'hFFFF_FFFF};
            else        res = {a % b, a / b};
         end
      endcase
      return res;
   endfunction

   function automatic int exp_lat(input logic [1:0] op, input logic [31:0] b);
      int n;
      logic [31:0] m;
      n = 0;
      m = (op == 2'b00 && b[31]) ? -b : b;
`ifdef MULDIV_EARLY_OUT_EN
      if (!op[1]) begin
         for (int i = 0; i < 32; i++) if (m[i]) n = i + 1;
         return 2 + ((n == 0) ? 1 : n);
      end
`endif
      if (m == 32'hDEAD_BEEF) n = 0;
      return 34 + n;
   endfunction

   // Scoreboard: every done pulse must match the oldest outstanding result.
   always @(negedge clk) begin
      if (reset && done) begin
         n_tests++;
         if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected_done: got hi=%h lo=%h, required no done", hi, lo);
         end else begin
            logic [63:0] e;
            e = sb_q.pop_front();
            if ({hi, lo} !== e) begin
               n_fail++;
               $display("FAIL sb_result: got %h_%h, required %h_%h", hi, lo, e[63:32], e[31:0]);
            end
         end
      end
   end

   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] got_hi, output logic [31:0] got_lo);
      logic [63:0] e;
      int lat, cyc;
      bit seen, busy_bad;
      e = model(op, a, b);
      lat = exp_lat(op, b);
      @(posedge clk); #1;
      start = 1'b1; op_in = op; src_a = a; src_b = b;
      sb_q.push_back(e);
      @(posedge clk); #1;
      start = 1'b0;
      cyc = 0; seen = 0; busy_bad = 0;
      while (!seen && cyc < 100) begin
         @(negedge clk);
         cyc++;
         if (done) seen = 1;
         else if (busy !== 1'b1) busy_bad = 1;
      end
      n_tests++;
      if (!seen) begin
         n_fail++;
         $display("FAIL done_timeout: got no done in %0d cycles, required done at %0d", cyc, lat);
      end else if (cyc != lat) begin
         n_fail++;
         $display("FAIL latency: got %0d cycles, required %0d", cyc, lat);
      end
      n_tests++;
      if (busy_bad) begin
         n_fail++;
         $display("FAIL busy_hold: got busy low before done, required busy high");
      end
      n_tests++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL busy_at_done: got %b, required 0", busy);
      end
      got_hi = hi;
      got_lo = lo;
      @(negedge clk);
      n_tests++;
      if (done !== 1'b0) begin
         n_fail++;
         $display("FAIL done_pulse: got %b one cycle later, required 0", done);
      end
      exp_hi = e[63:32];
      exp_lo = e[31:0];
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
      n_tests++;
      if (got !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h", name, got, req);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0; start = 0; abort = 0; hi_wr = 0; lo_wr = 0;
      op_in = 0; src_a = 0; src_b = 0; wr_data = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_busy", {31'b0, busy}, 0);
      chk("reset_done", {31'b0, done}, 0);
      chk("reset_hi", hi, 0);
      chk("reset_lo", lo, 0);
      @(posedge clk); #1;
      reset = 1'b1;
   endtask

   task automatic test_multu_max();
      logic [31:0] h, l;
      run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, h, l);
      chk("multu_max_hi", h, 32'hFFFF_FFFE);
      chk("multu_max_lo", l, 32'h0000_0001);
   endtask

   task automatic test_signed();
      logic [31:0] h, l;
      run_op(2'b00, -32'sd7, 32'd3, h, l);
      chk("mult_neg_hi", h, 32'hFFFF_FFFF);
      chk("mult_neg_lo", l, 32'hFFFF_FFEB);
      run_op(2'b10, -32'sd7, 32'd2, h, l);
      chk("div_neg_lo", l, 32'hFFFF_FFFD);
      chk("div_neg_hi", h, 32'hFFFF_FFFF);
   endtask

   task automatic test_div_corners();
      logic [31:0] h, l;
      run_op(2'b11, 32'd100, 32'd0, h, l);
      chk("divu_zero_lo", l, 32'hFFFF_FFFF);
      chk("divu_zero_hi", h, 32'd100);
      run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, h, l);
      chk("div_ovf_lo", l, 32'h8000_0000);
      chk("div_ovf_hi", h, 32'h0);
      run_op(2'b10, -32'sd9, 32'd0, h, l);
      chk("div_zero_neg_lo", l, 32'h1);
      chk("div_zero_neg_hi", h, -32'sd9);
   endtask

   task automatic test_abort();
      bit bad;
      @(posedge clk); #1;
      hi_wr = 1'b1; wr_data = 32'h1234;
      @(posedge clk); #1;
      hi_wr = 1'b0;
      exp_hi = 32'h1234;
      @(negedge clk);
      chk("mthi", hi, 32'h1234);
      chk("mthi_lo_kept", lo, exp_lo);
      @(posedge clk); #1;
      start = 1'b1; op_in = 2'b11; src_a = 9; src_b = 4;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      start = 1'b1; op_in = 2'b01; src_a = 3; src_b = 3;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      abort = 1'b1;
      @(negedge clk);
      chk("abort_busy_before", {31'b0, busy}, 1);
      @(posedge clk); #1;
      abort = 1'b0;
      @(negedge clk);
      chk("abort_busy_after", {31'b0, busy}, 0);
      chk("abort_hi", hi, 32'h1234);
      chk("abort_lo", lo, exp_lo);
      bad = 0;
      repeat (40) begin
         @(negedge clk);
         if (done || busy) bad = 1;
      end
      chk("abort_quiet", {31'b0, bad}, 0);
      @(posedge clk); #1;
      start = 1'b1; abort = 1'b1; op_in = 2'b01; src_a = 5; src_b = 5;
      @(posedge clk); #1;
      start = 1'b0; abort = 1'b0;
      @(negedge clk);
      chk("abort_start_idle", {31'b0, busy}, 0);
   endtask

   task automatic test_reset_mid();
      logic [31:0] h, l;
      @(posedge clk); #1;
      start = 1'b1; op_in = 2'b00; src_a = -32'sd5; src_b = 32'd123;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (19) @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      chk("rst_mid_busy", {31'b0, busy}, 0);
      chk("rst_mid_hi", hi, 0);
      chk("rst_mid_lo", lo, 0);
      exp_hi = 0; exp_lo = 0;
      run_op(2'b01, 32'd6, 32'd7, h, l);
      chk("after_rst_lo", l, 32'd42);
      chk("after_rst_hi", h, 32'd0);
   endtask

   task automatic test_mt_with_start();
      int cyc;
      @(posedge clk); #1;
      start = 1'b1; hi_wr = 1'b1; lo_wr = 1'b1; wr_data = 32'hCAFE;
      op_in = 2'b11; src_a = 9; src_b = 4;
      sb_q.push_back(model(2'b11, 32'd9, 32'd4));
      @(posedge clk); #1;
      start = 1'b0; hi_wr = 1'b0; lo_wr = 1'b0;
      @(negedge clk);
      chk("mt_start_hi", hi, 32'hCAFE);
      chk("mt_start_lo", lo, 32'hCAFE);
      cyc = 1;
      while (!done && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      chk("mt_start_done_cyc", cyc, 34);
      chk("mt_start_res_hi", hi, 32'd1);
      chk("mt_start_res_lo", lo, 32'd2);
      exp_hi = 1; exp_lo = 2;
   endtask

   task automatic test_early_out();
      logic [31:0] h, l;
      run_op(2'b01, 32'd5, 32'd1, h, l);
      chk("eo_lo", l, 32'd5);
      chk("eo_hi", h, 32'd0);
      run_op(2'b01, 32'd5, 32'd0, h, l);
      chk("eo_zero_lo", l, 32'd0);
      run_op(2'b00, -32'sd1000, 32'd40, h, l);
      chk("eo_mult_lo", l, -32'sd40000);
   endtask

   task automatic test_back_to_back();
      logic [31:0] h, l, a, b;
      logic [1:0]  op;
      for (int i = 0; i < 8; i++) begin
         op = 2'($urandom_range(0, 3));
         a = $urandom;
         b = (i == 3) ? 32'd1 : ((i == 5) ? 32'h8000_0000 : $urandom >> $urandom_range(0, 31));
         run_op(op, a, b, h, l);
      end
   endtask

   initial begin
      test_reset();
      test_multu_max();
      test_signed();
      test_div_corners();
      test_abort();
      test_reset_mid();
      test_mt_with_start();
      test_early_out();
      test_back_to_back();
      repeat (2) @(negedge clk);
      n_tests++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL sb_drain: got %0d pending results, required 0", sb_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got no finish, required finish before 2ms");
      $fatal(1, "timeout");
   end

endmodule
